// File: rtl/dma_mem_responder_if.sv
// DMA bus between the ecdsa initiator and a word-memory responder.
// Word payloads are 381 bits; addresses are byte addresses.
interface dma_mem_responder_if;
  logic [31:0]  dma_rx_address;
  logic         dma_rx_start;
  logic [380:0] dma_rx_data;
  logic [31:0]  dma_tx_address;
  logic [380:0] dma_tx_data;
  logic         dma_tx_start;
  logic         dma_done;
  logic         dma_idle;
  logic         dma_error;

  modport master (
    output dma_rx_address, dma_rx_start, dma_tx_address, dma_tx_data, dma_tx_start,
    input  dma_rx_data, dma_done, dma_idle, dma_error
  );

  modport slave (
    input  dma_rx_address, dma_rx_start, dma_tx_address, dma_tx_data, dma_tx_start,
    output dma_rx_data, dma_done, dma_idle, dma_error
  );
endinterface

// File: rtl/dma_mem_responder.sv
// Single-word DMA responder backed by a local memory, with fixed per-transfer
// latency, sticky error reporting and an always-available host access port.
module dma_mem_responder #(
  parameter int          DEPTH     = 64,
  parameter int          ADDR_LSB  = 7,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  dma_mem_responder_if.slave       dma,
  input  logic                     err_clear,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [380:0]             host_wdata,
  output logic [380:0]             host_rdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          is_read;
  logic          addr_ok;
  logic [AW-1:0] idx;
  logic [380:0]  wdata;
  logic [380:0]  mem [DEPTH];

  logic [31:0]   req_addr;
  logic [31:0]   offset;
  logic [31:0]   word_off;
  logic          req_ok;
  logic          any_start;
  logic          both_start;
  logic          err_set;
  logic          commit;

  // Decode whichever request is presented; a read takes priority over a write.
  always_comb begin
    req_addr = dma.dma_rx_start ? dma.dma_rx_address : dma.dma_tx_address;
    offset   = req_addr - BASE_ADDR;
    word_off = offset >> ADDR_LSB;
    req_ok   = (offset[ADDR_LSB-1:0] == '0) && (word_off < 32'(DEPTH));
  end

  assign any_start  = dma.dma_rx_start | dma.dma_tx_start;
  assign both_start = dma.dma_rx_start & dma.dma_tx_start;
  assign err_set    = (state == IDLE) ? (both_start | (any_start & ~req_ok)) : any_start;
  assign commit     = (state == DONE) & ~is_read & addr_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      is_read         <= 1'b0;
      addr_ok         <= 1'b0;
      idx             <= '0;
      wdata           <= '0;
      dma.dma_rx_data <= '0;
      dma.dma_done    <= 1'b0;
      dma.dma_idle    <= 1'b1;
      dma.dma_error   <= 1'b0;
    end else begin
      // A set in the same cycle as a clear wins.
      dma.dma_error <= err_set | (dma.dma_error & ~err_clear);
      case (state)
        IDLE: begin
          if (any_start) begin
            is_read      <= dma.dma_rx_start;
            addr_ok      <= req_ok;
            idx          <= word_off[AW-1:0];
            wdata        <= dma.dma_tx_data;
            cnt          <= 4'(LATENCY - 1);
            dma.dma_idle <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state        <= DONE;
            dma.dma_done <= 1'b1;
            if (is_read) dma.dma_rx_data <= addr_ok ? mem[idx] : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          dma.dma_done <= 1'b0;
          dma.dma_idle <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so its contents survive reset and it can map
  // onto block RAM. The DMA commit is written last so it wins on a same-index
  // collision with the host, and is gated by resetn so a reset drops it.
  always_ff @(posedge clk) begin
    if (host_we)          mem[host_addr] <= host_wdata;
    if (resetn && commit) mem[idx]       <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) host_rdata <= '0;
    else         host_rdata <= mem[host_addr];
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed and randomized bench for dma_mem_responder against an
// array-based reference memory and byte-address arithmetic model.
module tb_dma_mem_responder;
  localparam int          DEPTH    = 64;
  localparam int          ADDR_LSB = 7;
  localparam int          LATENCY  = 4;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam int          BEAT     = 2 ** ADDR_LSB;

  typedef logic [380:0] word_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        err_clear = 1'b0;
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  word_t       host_wdata = '0;
  word_t       host_rdata;

  dma_mem_responder_if bus ();

  dma_mem_responder #(
    .DEPTH(DEPTH), .ADDR_LSB(ADDR_LSB), .BASE_ADDR(BASE), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .resetn(resetn), .dma(bus.slave), .err_clear(err_clear),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_fail = 0;
  word_t ref_mem [DEPTH];
  bit    ref_err = 1'b0;
  word_t ref_rx = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t rand_word();
    logic [383:0] t;
    for (int k = 0; k < 12; k++) t[k*32 +: 32] = $urandom;
    return t[380:0];
  endfunction

  function automatic bit ref_valid(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off % BEAT == 0) && (off / BEAT < DEPTH);
  endfunction

  task automatic host_write(input int i, input word_t d);
    host_we = 1'b1; host_addr = 6'(i); host_wdata = d;
    tick();
    host_we = 1'b0;
    ref_mem[i] = d;
  endtask

  task automatic host_read(input string tag, input int i);
    host_addr = 6'(i);
    tick();
    check(tag, host_rdata, ref_mem[i]);
  endtask

  task automatic scan_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) host_read(tag, i);
  endtask

  // One DMA transaction; poke = cycle (after start) to inject a stray rx_start,
  // hpoke = issue a host write to hidx during the done cycle.
  task automatic dma(input string tag, input bit rx, input bit tx,
                     input logic [31:0] ra, input logic [31:0] ta, input word_t d,
                     input int poke, input bit hpoke, input int hidx, input word_t hdata);
    logic [31:0] a;
    bit ok;
    int idx, n_done, done_cyc;
    check({tag, ":idle_pre"}, word_t'(bus.dma_idle), 1);
    bus.dma_rx_start = rx; bus.dma_tx_start = tx;
    bus.dma_rx_address = ra; bus.dma_tx_address = ta; bus.dma_tx_data = d;
    tick();
    bus.dma_rx_start = 1'b0; bus.dma_tx_start = 1'b0;
    a   = rx ? ra : ta;
    ok  = ref_valid(a);
    idx = ok ? int'((a - BASE) / BEAT) : 0;
    if ((rx && tx) || !ok || poke > 0) ref_err = 1'b1;
    check({tag, ":idle_busy"}, word_t'(bus.dma_idle), 0);
    n_done = 0; done_cyc = 0;
    for (int c = 1; c <= LATENCY + 3; c++) begin
      if (bus.dma_done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == LATENCY + 1 && rx) begin
        ref_rx = ok ? ref_mem[idx] : '0;
        check({tag, ":rx_data"}, bus.dma_rx_data, ref_rx);
      end
      if (c == LATENCY + 2) check({tag, ":idle_after"}, word_t'(bus.dma_idle), 1);
      bus.dma_rx_start = (c == poke);
      if (hpoke && c == LATENCY + 1) begin
        host_we = 1'b1; host_addr = 6'(hidx); host_wdata = hdata; ref_mem[hidx] = hdata;
      end else begin
        host_we = 1'b0;
      end
      tick();
    end
    host_we = 1'b0;
    if (!rx && ok) ref_mem[idx] = d;
    check({tag, ":n_done"}, word_t'(n_done), 1);
    check({tag, ":done_cyc"}, word_t'(done_cyc), word_t'(LATENCY + 1));
    check({tag, ":rx_hold"}, bus.dma_rx_data, ref_rx);
    check({tag, ":error"}, word_t'(bus.dma_error), word_t'(ref_err));
    host_read({tag, ":mem"}, idx);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    ref_err = 1'b0;
    check("err_clear", word_t'(bus.dma_error), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t in_tbl, out_tbl, v;
    logic [31:0] ea;
    int n_done;

    bus.dma_rx_start = 1'b0; bus.dma_tx_start = 1'b0;
    bus.dma_rx_address = '0; bus.dma_tx_address = '0; bus.dma_tx_data = '0;

    // Reset state
    repeat (3) tick();
    check("rst_idle", word_t'(bus.dma_idle), 1);
    check("rst_done", word_t'(bus.dma_done), 0);
    check("rst_error", word_t'(bus.dma_error), 0);
    check("rst_rx_data", bus.dma_rx_data, '0);
    check("rst_host_rdata", host_rdata, '0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) host_write(i, rand_word());

    // Read latency and write read-back
    host_write(3, 381'h1234);
    dma("rd3", 1, 0, 32'h180, 32'h0, '0, 0, 0, 0, '0);
    check("rd3_value", bus.dma_rx_data, 381'h1234);
    dma("wr1", 0, 1, 32'h0, 32'h80, 381'hABCD, 0, 0, 0, '0);
    host_read("wr1_readback", 1);
    check("wr1_value", host_rdata, 381'hABCD);

    // Invalid accesses and error clear
    dma("rd_mis", 1, 0, 32'h41, 32'h0, '0, 0, 0, 0, '0);
    check("rd_mis_zero", bus.dma_rx_data, '0);
    dma("wr_oob", 0, 1, 32'h0, 32'h2000, rand_word(), 0, 0, 0, '0);
    scan_mem("wr_oob_scan");
    check("err_held", word_t'(bus.dma_error), 1);
    clear_err();

    // Collisions
    dma("both", 1, 1, 32'h180, 32'h100, rand_word(), 0, 0, 0, '0);
    host_read("both_w2", 2);
    clear_err();
    dma("poke_busy", 1, 0, 32'h80, 32'h0, '0, 2, 0, 0, '0);
    clear_err();
    dma("poke_done", 0, 1, 32'h0, 32'h300, rand_word(), LATENCY + 1, 0, 0, '0);
    clear_err();
    dma("host_same", 0, 1, 32'h0, 32'h280, rand_word(), 0, 1, 5, rand_word());
    dma("host_diff", 0, 1, 32'h0, 32'h280, rand_word(), 0, 1, 7, rand_word());
    host_read("host_diff_w7", 7);

    // Reset during BUSY of a write to word 2
    bus.dma_tx_start = 1'b1; bus.dma_tx_address = 32'h100; bus.dma_tx_data = rand_word();
    tick();
    bus.dma_tx_start = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    ref_err = 1'b0; ref_rx = '0;
    n_done = 0;
    for (int c = 0; c < LATENCY + 3; c++) begin
      if (bus.dma_done) n_done++;
      tick();
    end
    check("rst_mid_done", word_t'(n_done), 0);
    check("rst_mid_idle", word_t'(bus.dma_idle), 1);
    check("rst_mid_rx", bus.dma_rx_data, '0);
    host_read("rst_mid_w2", 2);

    // Initiator loopback: input table at word 10, output table at word 11
    in_tbl = '0; out_tbl = '0;
    for (int k = 0; k < 3; k++) begin
      in_tbl[380 - 32*k -: 32]  = BASE + 32'((20 + k) * BEAT);
      out_tbl[380 - 32*k -: 32] = BASE + 32'((30 + k) * BEAT);
    end
    host_write(10, in_tbl);
    host_write(11, out_tbl);
    dma("lb_in_tbl", 1, 0, BASE + 32'(10 * BEAT), 32'h0, '0, 0, 0, 0, '0);
    dma("lb_out_tbl", 1, 0, BASE + 32'(11 * BEAT), 32'h0, '0, 0, 0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      ea = ref_mem[10][380 - 32*k -: 32];
      dma("lb_val", 1, 0, ea, 32'h0, '0, 0, 0, 0, '0);
    end
    for (int k = 0; k < 3; k++) begin
      ea = ref_mem[11][380 - 32*k -: 32];
      v  = rand_word();
      dma("lb_res", 0, 1, 32'h0, ea, v, 0, 0, 0, '0);
    end
    check("lb_error", word_t'(bus.dma_error), 0);

    // Randomized mix of reads and writes, some misaligned
    for (int n = 0; n < 12; n++) begin
      logic [31:0] ad;
      ad = BASE + 32'($urandom_range(0, DEPTH - 1) * BEAT);
      if ($urandom_range(0, 3) == 0) ad = ad + 32'($urandom_range(1, BEAT - 1));
      if ($urandom_range(0, 1) == 1) dma("rnd_rd", 1, 0, ad, 32'h0, '0, 0, 0, 0, '0);
      else                           dma("rnd_wr", 0, 1, 32'h0, ad, rand_word(), 0, 0, 0, '0);
    end
    scan_mem("final_scan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_mem_responder.md
Name: dma_mem_responder

Overview:
- Responder end of the 381-bit DMA interface that the ecdsa top drives as initiator.
- Services single-word reads (dma_rx_start) and writes (dma_tx_start) from a local word memory with configurable latency.
- Lets block-level benches and standalone FPGA bring-up exercise the command FSM, argument tables and output tables without the AXI interfacer.
- A host port preloads argument tables and values and reads back results.

Parameters:
- DEPTH, 64: number of 381-bit words; power of two.
- ADDR_LSB, 7: byte-address bits per word (128-byte beat); these low bits must be zero.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- LATENCY, 4: cycles spent in BUSY per transfer; legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- dma_rx_address  in  32  read byte address, sampled with dma_rx_start
- dma_rx_start  in  1  read request pulse
- dma_rx_data  out  381  read data, valid from dma_done onward
- dma_tx_address  in  32  write byte address, sampled with dma_tx_start
- dma_tx_data  in  381  write data, sampled with dma_tx_start
- dma_tx_start  in  1  write request pulse
- dma_done  out  1  one-cycle completion pulse
- dma_idle  out  1  high when a new request will be accepted
- dma_error  out  1  sticky error flag
- err_clear  in  1  clears dma_error
- host_we  in  1  host write enable
- host_addr  in  log2(DEPTH)  host word index
- host_wdata  in  381  host write data
- host_rdata  out  381  host read data, registered, 1-cycle latency

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Reset values: state IDLE, dma_idle=1, dma_done=0, dma_error=0, dma_rx_data=0, host_rdata=0. Memory contents are not cleared.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - A start seen at edge N latches the direction, the address and, for a write, the data.
  - The FSM enters BUSY; dma_idle=0 from N+1.
  - If rx_start and tx_start are both high: the read is served, the write is dropped and dma_error is set.
- BUSY:
  - A down-counter is loaded with LATENCY-1.
  - At 0 the FSM moves to DONE, so BUSY lasts exactly LATENCY cycles.
  - Start pulses received in BUSY or DONE are ignored and set dma_error.
- DONE:
  - dma_done=1 for exactly one cycle.
  - A read places its word on dma_rx_data in this cycle; dma_rx_data then holds until the next read completes.
  - A write commits its word to memory in this cycle.
  - Next state is IDLE, with dma_idle=1.
  - Total timing: start at edge N gives dma_done high in cycle N+1+LATENCY.
- Address decode:
  - offset = address − BASE_ADDR (32-bit wrap-around).
  - idx = offset >> ADDR_LSB.
  - The access is invalid if offset[ADDR_LSB-1:0] != 0 or idx >= DEPTH.
- Invalid access:
  - The full latency and the done pulse still occur.
  - Memory is untouched; a read returns 381'b0.
  - dma_error is set.
- dma_error:
  - Set as described above; held until err_clear or reset.
  - A set and a clear in the same cycle leave it set.
- Host port:
  - host_we writes host_wdata to host_addr.
  - host_rdata returns the word at host_addr on the next cycle (old data on a same-cycle write).
  - When a DMA write commit and host_we target the same index in the same cycle, the DMA data wins.
  - The host port works in every state.
- Reset in BUSY or DONE: returns to IDLE immediately, any pending write is dropped, no done pulse.
- Word packing is MSB-first, as the initiator expects: table entry k occupies bits [380-32k -: 32].

Test Plan:
- Read latency:
  - Host-write word 3 = 381'h1234.
  - Pulse rx_start with address 32'h180 (LATENCY=4).
  - Required: dma_idle low 1 cycle later, dma_done high exactly 5 cycles after the start edge, dma_rx_data=381'h1234, dma_idle high the cycle after done.
- Write then read-back:
  - tx_start with address 32'h80 and data 381'hABCD.
  - After done, host_addr=1 returns 381'hABCD; dma_error stays 0.
- Errors:
  - Read of address 32'h0000_0041 (misaligned) gives done, rx data 0 and dma_error=1.
  - Write to index 64 (address 32'h2000) gives done, no memory change and error held.
  - err_clear brings dma_error to 0.
- Collisions:
  - Simultaneous rx_start and tx_start: the read completes, memory is unchanged, dma_error=1.
  - rx_start during BUSY is ignored (only one done pulse) and sets the error.
- Reset mid-operation:
  - Assert resetn=0 during BUSY of a write to word 2.
  - Required: word 2 unchanged, no dma_done, dma_idle=1 after reset.
- Initiator loopback:
  - Preload a 3-entry output table and an input table pointing to 3 values, then drive the sequence a mont-mult command produces.
  - Every request gets exactly one done pulse, values return in order, no error.
